// File: rtl/sha1_block_feeder.sv
// Packs 32-bit big-endian message words into 512-bit SHA-1 blocks and appends the padding and bit length.
// Latency: a block is valid the cycle after its last word is accepted; word input stalls while a block is offered.
module sha1_block_feeder #(
  parameter int BCNT_W = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  word_in,
  input  logic         word_valid,
  input  logic         word_last,
  input  logic [2:0]   word_bytes,
  output logic         word_ready,
  output logic [511:0] block,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
  typedef enum logic [1:0] {NX_FILL, NX_TAIL0, NX_TAIL80, NX_IDLE} nxt_t;

  state_t              state_q, state_d;
  nxt_t                nxt_q, nxt_d;
  logic [511:0]        blk_q, blk_d;
  logic [3:0]          widx_q, widx_d;
  logic [BCNT_W-1:0]   cnt_q, cnt_d, cnt_sum;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic [2:0]          nb;
  logic [6:0]          pos;
  logic [31:0]         mask;
  logic [63:0]         len_new, len_cur;

  // Non-last words always count as 4 bytes; out-of-range tails are clamped to a full word.
  assign nb      = (!word_last || word_bytes > 3'd4) ? 3'd4 : word_bytes;
  assign cnt_sum = cnt_q + BCNT_W'(nb);
  assign len_new = 64'({cnt_sum, 3'b000});
  assign len_cur = 64'({cnt_q, 3'b000});
  assign pos     = {1'b0, widx_q, 2'b00} + {4'b0000, nb};

  always_comb begin
    case (nb)
      3'd0:    mask = 32'h0000_0000;
      3'd1:    mask = 32'hFF00_0000;
      3'd2:    mask = 32'hFFFF_0000;
      3'd3:    mask = 32'hFFFF_FF00;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    blk_d   = blk_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d   = '0;
          widx_d  = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (word_valid) begin
          blk_d[{~widx_q, 5'b00000} +: 32] = word_in & mask;
          cnt_d  = cnt_sum;
          widx_d = widx_q + 4'd1;
          if (word_last) begin
            state_d = EMIT;
            if (pos < 7'd64) blk_d[{~pos[5:0], 3'b000} +: 8] = 8'h80;
            if (pos <= 7'd55) begin
              blk_d[63:0] = len_new;
              last_d      = 1'b1;
              nxt_d       = NX_IDLE;
            end else if (pos <= 7'd63) begin
              last_d = 1'b0;
              nxt_d  = NX_TAIL0;
            end else begin
              last_d = 1'b0;
              nxt_d  = NX_TAIL80;
            end
          end else if (widx_q == 4'd15) begin
            state_d = EMIT;
            last_d  = 1'b0;
            nxt_d   = NX_FILL;
          end
        end
      end
      EMIT: begin
        if (block_ready) begin
          blk_d  = '0;
          widx_d = '0;
          case (nxt_q)
            NX_FILL: begin
              last_d  = 1'b0;
              state_d = FILL;
            end
            NX_TAIL0: begin
              blk_d[63:0] = len_cur;
              last_d      = 1'b1;
              nxt_d       = NX_IDLE;
            end
            NX_TAIL80: begin
              blk_d[511:504] = 8'h80;
              blk_d[63:0]    = len_cur;
              last_d         = 1'b1;
              nxt_d          = NX_IDLE;
            end
            default: begin
              last_d  = 1'b0;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      nxt_q   <= NX_IDLE;
      blk_q   <= '0;
      widx_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      blk_q   <= blk_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign word_ready  = (state_q == FILL);
  assign block_valid = (state_q == EMIT);
  assign block       = blk_q;
  assign block_last  = last_q;
  assign busy        = busy_q;

endmodule
